// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter/sequencer for a shared 4:1 selector.
// Ports: clk, rst_n, req[3:0], a..d[W], out_ready -> out_valid, z, s, gnt, ack, busy.
// Optional build macro MUX4_ARB_FIXED_PRIO_EN: fixed priority (0 highest), no ptr.
module mux4_rr_arbiter #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] z,
  output logic [1:0]   s,
  output logic [3:0]   gnt,
  output logic [3:0]   ack,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] LAST = 4'(BURST - 1);

  state_t       state_q, state_d;
  logic [1:0]   s_q, s_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   ptr;
  logic [1:0]   win;
  logic         win_vld;
  logic         rel;
  logic         xfer;
  logic [W-1:0] sel;

  // Search starts at ptr; scanning the offsets downward lets the
  // nearest set bit overwrite any farther one.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win     = ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (s_q)
      2'd0:    sel = a;
      2'd1:    sel = b;
      2'd2:    sel = c;
      default: sel = d;
    endcase
  end

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req[s_q];
  assign xfer      = out_valid & out_ready;
  assign gnt       = busy ? (4'b0001 << s_q) : 4'b0000;
  assign ack       = xfer ? gnt : 4'b0000;
  assign z         = out_valid ? sel : '0;
  assign s         = s_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          s_d     = win;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A transfer implies req[s] is still high.
        if (xfer && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 4'd1;
        end else if (xfer || !req[s_q]) begin
          state_d = IDLE;
          rel     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MUX4_ARB_FIXED_PRIO_EN
  assign ptr = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;

  assign ptr_d = rel ? (s_q + 2'd1) : ptr_q;
  assign ptr   = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter.
// Two instances: BURST=4 (dut) and BURST=1 (dut1).
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic [3:0] ack;
    logic [7:0] z;
  } beat_t;

`ifdef MUX4_ARB_FIXED_PRIO_EN
  localparam logic [3:0] ALL_GNT = 4'b0001;
`else
  localparam logic [3:0] ALL_GNT = 4'b1000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req1;
  logic [7:0] a, b, c, d;
  logic       out_ready;

  logic       ov, ov1, busy, busy1;
  logic [7:0] z, z1;
  logic [1:0] s, s1;
  logic [3:0] gnt, gnt1, ack, ack1;

  beat_t exp_q[$];
  beat_t e;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.W(8), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(ov), .z(z),
    .s(s), .gnt(gnt), .ack(ack), .busy(busy)
  );

  mux4_rr_arbiter #(.W(8), .BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .out_valid(ov1), .z(z1),
    .s(s1), .gnt(gnt1), .ack(ack1), .busy(busy1)
  );

  task automatic test_reset();
    rst_n = 1'b0; req = 4'hF; req1 = 4'hF;
    a = 8'h00; b = 8'h0F; c = 8'hF0; d = 8'hFF;
    out_ready = 1'b1;
    #12;
    n_tests++;
    if ({ov, gnt, z, s, ack, busy} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset: ov/gnt/z/s/ack/busy=%b/%b/%h/%b/%b/%b want 0",
               ov, gnt, z, s, ack, busy);
    end
    n_tests++;
    if ({ov1, gnt1, z1, s1, ack1, busy1} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_b1: ov/gnt/z=%b/%b/%h want 0", ov1, gnt1, z1);
    end
    req = 4'h0; req1 = 4'h0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int k = 0; k < 4; k++) exp_q.push_back('{4'b0100, 8'hF0});
    @(posedge clk); #1 req = 4'b0100; out_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 8 && beats < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_tests++;
        if (gnt !== 4'b0000) begin
          n_fail++;
          $display("FAIL single_latency: gnt=%b want 0000", gnt);
        end
      end
      if (i == 1) begin
        n_tests++;
        if ({gnt, s, z, ov} !== {4'b0100, 2'b10, 8'hF0, 1'b1}) begin
          n_fail++;
          $display("FAIL single_grant: gnt/s/z/ov=%b/%b/%h/%b want 0100/10/f0/1",
                   gnt, s, z, ov);
        end
      end
      if (ack != 4'b0000) begin
        beats++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL single_beat: unexpected ack=%b", ack);
        end else begin
          e = exp_q.pop_front();
          if ({ack, z} !== e) begin
            n_fail++;
            $display("FAIL single_beat: ack/z=%b/%h want %b/%h",
                     ack, z, e.ack, e.z);
          end
        end
      end
    end
    n_tests++;
    if (beats !== 4) begin
      n_fail++;
      $display("FAIL single_count: beats=%0d want 4", beats);
    end
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({busy, gnt, ack} !== 9'd0) begin
      n_fail++;
      $display("FAIL single_idle: busy/gnt/ack=%b/%b/%b want 0", busy, gnt, ack);
    end
    @(posedge clk); #1 req = 4'hF; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== ALL_GNT) begin
      n_fail++;
      $display("FAIL single_ptr: gnt=%b want %b", gnt, ALL_GNT);
    end
    @(posedge clk); #1 req = 4'h0;
    @(negedge clk);
    @(negedge clk);
  endtask

`ifndef MUX4_ARB_FIXED_PRIO_EN
  task automatic test_round_robin();
    exp_q.push_back('{4'b0001, 8'h00});
    exp_q.push_back('{4'b0010, 8'h0F});
    exp_q.push_back('{4'b0100, 8'hF0});
    exp_q.push_back('{4'b1000, 8'hFF});
    exp_q.push_back('{4'b0001, 8'h00});
    @(posedge clk); #1 req1 = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ((i % 2 == 1) !== (ack1 != 4'b0000)) begin
        n_fail++;
        $display("FAIL rr_bubble: cycle %0d ack=%b busy=%b", i, ack1, busy1);
      end
      if (ack1 != 4'b0000) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_beat: unexpected ack=%b", ack1);
        end else begin
          e = exp_q.pop_front();
          if ({ack1, z1} !== e || gnt1 !== e.ack) begin
            n_fail++;
            $display("FAIL rr_beat: ack/gnt/z=%b/%b/%h want %b/%h",
                     ack1, gnt1, z1, e.ack, e.z);
          end
        end
      end
    end
    @(posedge clk); #1 req1 = 4'h0;
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rr_left: %0d beats not seen want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) exp_q.push_back('{4'b0010, 8'h0F});
    @(posedge clk); #1 req = 4'b0010; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ov, z, gnt, ack} !== {1'b1, 8'h0F, 4'b0010, 4'b0000}) begin
        n_fail++;
        $display("FAIL bp_hold: ov/z/gnt/ack=%b/%h/%b/%b want 1/0f/0010/0000",
                 ov, z, gnt, ack);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 8 && beats < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_tests++;
        if (ack !== 4'b0010) begin
          n_fail++;
          $display("FAIL bp_release: ack=%b want 0010", ack);
        end
      end
      if (ack != 4'b0000) begin
        beats++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_beat: unexpected ack=%b", ack);
        end else begin
          e = exp_q.pop_front();
          if ({ack, z} !== e) begin
            n_fail++;
            $display("FAIL bp_beat: ack/z=%b/%h want %b/%h",
                     ack, z, e.ack, e.z);
          end
        end
      end
    end
    n_tests++;
    if (beats !== 4) begin
      n_fail++;
      $display("FAIL bp_count: beats=%0d want 4", beats);
    end
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_withdraw_reset();
    exp_q.push_back('{4'b1000, 8'hFF});
    @(posedge clk); #1 req = 4'b1000; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() == 0 || ack == 4'b0000) begin
      n_fail++;
      $display("FAIL wd_beat: ack=%b want 1000", ack);
    end else begin
      e = exp_q.pop_front();
      if ({ack, z} !== e) begin
        n_fail++;
        $display("FAIL wd_beat: ack/z=%b/%h want %b/%h", ack, z, e.ack, e.z);
      end
    end
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    n_tests++;
    if ({ov, ack, z, busy} !== {1'b0, 4'b0000, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL wd_drop: ov/ack/z/busy=%b/%b/%h/%b want 0/0000/00/1",
               ov, ack, z, busy);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, gnt} !== 5'd0) begin
      n_fail++;
      $display("FAIL wd_idle: busy/gnt=%b/%b want 0", busy, gnt);
    end
    @(posedge clk); #1 req = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL wd_ptr: gnt=%b want 0001", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ov, z, gnt, ack, busy, s} !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_mid: ov/z/gnt/ack/busy/s=%b/%h/%b/%b/%b/%b want 0",
               ov, z, gnt, ack, busy, s);
    end
    req = 4'h0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ack, busy} !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_after: ack/busy=%b/%b want 0", ack, busy);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL wd_left: %0d beats not seen want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

`ifdef MUX4_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    for (int k = 0; k < 5; k++) exp_q.push_back('{4'b0010, 8'h0F});
    @(posedge clk); #1 req1 = 4'b1010; out_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (gnt1[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL fp_gnt3: gnt=%b want bit3 low", gnt1);
      end
      if (ack1 != 4'b0000) begin
        beats++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fp_beat: unexpected ack=%b", ack1);
        end else begin
          e = exp_q.pop_front();
          if ({ack1, z1} !== e) begin
            n_fail++;
            $display("FAIL fp_beat: ack/z=%b/%h want %b/%h",
                     ack1, z1, e.ack, e.z);
          end
        end
      end
    end
    @(posedge clk); #1 req1 = 4'h0;
    n_tests++;
    if (beats !== 5) begin
      n_fail++;
      $display("FAIL fp_count: beats=%0d want 5", beats);
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
`ifdef MUX4_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_backpressure();
    test_withdraw_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Four-way round-robin arbiter and sequencer for the shared 4:1 W-bit selector datapath (inputs a/b/c/d, select s, output z).
- Each source raises a request, holds it, and receives a grant. The block drives the select, presents the chosen source's data downstream with a valid/ready handshake, and returns a per-source acknowledge for every accepted beat.
- A grant may be held for a bounded burst.
- It sits between the four data producers and the single downstream consumer of z.

## Interface
Parameters:
- W, 8, data width of a, b, c, d and z.
- BURST, 4, maximum beats accepted per grant; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request per source; bit i corresponds to source i (0=a, 1=b, 2=c, 3=d).
- a, b, c, d  in  W  source data.
- out_ready  in  1  downstream can accept z this cycle.
- out_valid  out  1  z holds a valid beat.
- z  out  W  selected data; forced to 0 when out_valid=0.
- s  out  2  registered select value of the current or last grant.
- gnt  out  4  one-hot grant; all zero when idle.
- ack  out  4  one-cycle pulse on bit i when a beat from source i is accepted.
- busy  out  1  high in GRANT state.

## Operation
- State machine has two states: IDLE and GRANT.
- Registers: state, s, ptr (2-bit round-robin pointer), cnt (4-bit beat count).

IDLE:
- out_valid=0, gnt=0.
- If req≠0, the winner is the first set bit of req searching ptr, ptr+1, ... mod 4.
- On a win: s←winner, cnt←0, state←GRANT.
- If req=0, stay in IDLE.

GRANT:
- gnt=1<<s, out_valid=req[s], z=mux(s), busy=1.

Transfers:
- Transfer occurs when out_valid & out_ready.
- ack[s]=1 in that same cycle (combinational from registered gnt and out_ready); all other ack bits are 0.
- On a transfer with cnt<BURST-1 and req[s] still high in that cycle: cnt←cnt+1, stay in GRANT.
- On a transfer with cnt=BURST-1 or req[s] low in that cycle: ptr←s+1 (mod 4), state←IDLE.

Request withdrawn:
- If req[s] is low with no transfer, out_valid is 0 that cycle.
- The grant is released: ptr←s+1, state←IDLE, no ack.

Data rules:
- z is unregistered from a/b/c/d. Sources must hold data stable while granted until ack.
- Requests from non-granted sources are ignored until the block returns to IDLE. No pre-emption.
- Arithmetic: ptr wraps 3→0 (mod 4); cnt never exceeds BURST-1.

## Timing
- Reset (async, rst_n=0): state=IDLE, s=0, ptr=0, cnt=0.
- Output values in reset: out_valid=0, z=0, gnt=0, ack=0, busy=0.
- Latency: req rising in an IDLE cycle n gives gnt/out_valid in cycle n+1.
- Minimum one IDLE bubble between successive grants.
- Throughput: one beat per cycle within a burst while out_ready=1.
- out_ready low: out_valid, z and gnt hold and cnt holds. No ack.
- Simultaneous requests in IDLE: the ptr-ordered winner takes the grant.
- Reset asserted mid-burst: all outputs go to reset values immediately. The partial burst is dropped with no further ack.
- BURST=1: every grant ends after one beat.

## Configuration
- Macro: MUX4_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority (0 highest, 3 lowest). ptr is not implemented and always reads 0. BURST limits still apply.
- Undefined (default): round-robin as specified above.

## Test plan
- Reset: rst_n=0 with req=4'b1111 -> out_valid=0, gnt=0, z=0, s=0.
- Single source: req=4'b0100, c=8'hF0, out_ready=1 -> gnt=4'b0100, s=2'b10, z=8'hF0 one cycle later. ack[2] pulses on each of 4 consecutive beats, then IDLE, ptr=3.
- Round-robin: req=4'b1111 held, BURST=1, a/b/c/d=8'h00/0F/F0/FF -> z sequence 00, 0F, F0, FF, 00 with one idle cycle between each. gnt order 0, 1, 2, 3, 0.
- Backpressure: granted source 1, out_ready low for 3 cycles -> z=8'h0F and out_valid held, no ack, cnt unchanged. out_ready high -> ack[1] that cycle.
- Withdrawal/reset: req[3] dropped mid-burst -> out_valid=0 that cycle, IDLE next cycle, ptr=0. rst_n pulsed low mid-burst -> outputs zero immediately.
- Fixed priority (macro defined): req=4'b1010 held, BURST=1 -> source 1 wins every arbitration and source 3 is never granted.
